range_monitor: RTL and testbench

- Downstream consumer of the ultrasonic sensor driver's distance samples (8-bit, cm, one strobe per 0.5 s measurement).
- Drops invalid zero readings, smooths samples with a power-of-two moving average, and classifies the averaged range into CLEAR / NEAR / STOP zones with hysteresis.
- Flags a sensor fault when no valid sample arrives within a timeout.
- Drives the `obstacle` signal consumed by motor control.

---
 rtl/range_monitor.sv | 249 ++++++++++++++++++++++++
 tb/tb_range_monitor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/range_monitor.sv
// ---------------------------------------------------------------------------
// range_monitor
//   Consumes distance samples from the ultrasonic sensor driver, drops zero
//   readings, smooths them with a power-of-two moving average and classifies
//   the average into CLEAR / NEAR / STOP zones with hysteresis. A sample
//   timeout raises sensor_fault. obstacle is the stop request for motor
//   control.
//
//   Optional build macro: RANGE_MONITOR_MEDIAN3_EN
//     When defined, a registered median-of-3 filter over the last three
//     accepted raw samples feeds the averaging buffer.
// ---------------------------------------------------------------------------
module range_monitor #(
   parameter int DW             = 8,
   parameter int AVG_LOG2       = 2,
   parameter int NEAR_CM        = 40,
   parameter int STOP_CM        = 20,
   parameter int HYST_CM        = 5,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   input  logic          sample_valid,
   input  logic [DW-1:0] sample_distance,
   output logic [DW-1:0] avg_distance,
   output logic          avg_valid,
   output logic          ready,
   output logic [1:0]    zone,
   output logic          sensor_fault,
   output logic          obstacle
);

   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int SW    = DW + AVG_LOG2;
   localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [AVG_LOG2:0]   FILL_FULL = (AVG_LOG2 + 1)'(DEPTH);
   localparam logic [AVG_LOG2:0]   FILL_ONE  = (AVG_LOG2 + 1)'(1);
   localparam logic [AVG_LOG2-1:0] WR_ONE    = AVG_LOG2'(1);
   localparam logic [TW-1:0]       TMO_MAX   = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0]       TMO_ONE   = TW'(1);

   // Thresholds are held one bit wider than the samples so the release
   // levels (threshold + hysteresis) cannot wrap.
   localparam logic [DW:0] NEAR_T   = (DW + 1)'(NEAR_CM);
   localparam logic [DW:0] STOP_T   = (DW + 1)'(STOP_CM);
   localparam logic [DW:0] NEAR_REL = (DW + 1)'(NEAR_CM + HYST_CM);
   localparam logic [DW:0] STOP_REL = (DW + 1)'(STOP_CM + HYST_CM);

   typedef enum logic [1:0] {
      ZONE_CLEAR = 2'd0,
      ZONE_NEAR  = 2'd1,
      ZONE_STOP  = 2'd2
   } zone_e;

   // Averaging state
   logic [DW-1:0]       buf_r [DEPTH];
   logic [SW-1:0]       sum_r;
   logic [AVG_LOG2-1:0] wr_r;
   logic [AVG_LOG2:0]   fill_r;
   logic [TW-1:0]       tmo_r;
   zone_e               zone_r;

   // Next-state signals
   logic                accept_s;
   logic                buf_acc_s;
   logic [DW-1:0]       buf_in_s;
   logic [SW-1:0]       new_sum_s;
   logic [DW-1:0]       new_avg_s;
   logic [DW:0]         avg_ext_s;
   logic [AVG_LOG2:0]   fill_next_s;
   logic                ready_next_s;
   logic                avg_upd_s;
   logic [TW-1:0]       tmo_next_s;
   logic                fault_next_s;
   zone_e               zone_next_s;

   // A zero reading is treated as "no echo" and ignored entirely.
   assign accept_s = sample_valid && (sample_distance != {DW{1'b0}});

`ifdef RANGE_MONITOR_MEDIAN3_EN
   logic [DW-1:0] raw1_r;
   logic [DW-1:0] raw2_r;
   logic [1:0]    prime_r;
   logic [DW-1:0] med_r;
   logic          med_vld_r;

   function automatic logic [DW-1:0] med3(input logic [DW-1:0] a,
                                          input logic [DW-1:0] b,
                                          input logic [DW-1:0] c);
      logic [DW-1:0] lo;
      logic [DW-1:0] hi;
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      if (c <= lo) begin
         med3 = lo;
      end else if (c >= hi) begin
         med3 = hi;
      end else begin
         med3 = c;
      end
   endfunction

   // Median window: first two accepts only prime it, then each accept
   // produces a registered median one cycle later.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         raw1_r    <= {DW{1'b0}};
         raw2_r    <= {DW{1'b0}};
         prime_r   <= 2'd0;
         med_r     <= {DW{1'b0}};
         med_vld_r <= 1'b0;
      end else if (accept_s) begin
         raw1_r <= sample_distance;
         raw2_r <= raw1_r;
         if (prime_r == 2'd2) begin
            med_r     <= med3(sample_distance, raw1_r, raw2_r);
            med_vld_r <= 1'b1;
         end else begin
            prime_r   <= prime_r + 2'd1;
            med_vld_r <= 1'b0;
         end
      end else begin
         med_vld_r <= 1'b0;
      end
   end

   assign buf_acc_s = med_vld_r;
   assign buf_in_s  = med_r;
`else
   assign buf_acc_s = accept_s;
   assign buf_in_s  = sample_distance;
`endif

   // Running sum with the oldest entry swapped for the incoming one.
   assign new_sum_s    = sum_r - SW'(buf_r[wr_r]) + SW'(buf_in_s);
   assign new_avg_s    = DW'(new_sum_s >> AVG_LOG2);
   assign avg_ext_s    = {1'b0, new_avg_s};
   assign fill_next_s  = (buf_acc_s && (fill_r != FILL_FULL)) ? (fill_r + FILL_ONE) : fill_r;
   assign ready_next_s = (fill_next_s == FILL_FULL);
   assign avg_upd_s    = buf_acc_s && ready_next_s;

   // Timeout counter and fault: an accept always wins over reaching the limit.
   always_comb begin
      tmo_next_s   = tmo_r;
      fault_next_s = sensor_fault;
      if (accept_s) begin
         tmo_next_s   = {TW{1'b0}};
         fault_next_s = 1'b0;
      end else if (tmo_r == TMO_MAX) begin
         tmo_next_s   = TMO_MAX;
         fault_next_s = 1'b1;
      end else begin
         tmo_next_s   = tmo_r + TMO_ONE;
         fault_next_s = ((tmo_r + TMO_ONE) == TMO_MAX);
      end
   end

   // Zone next-state: evaluated only when a new average is produced.
   always_comb begin
      zone_next_s = zone_r;
      if (avg_upd_s) begin
         case (zone_r)
            ZONE_CLEAR: begin
               if (avg_ext_s < STOP_T) begin
                  zone_next_s = ZONE_STOP;
               end else if (avg_ext_s < NEAR_T) begin
                  zone_next_s = ZONE_NEAR;
               end else begin
                  zone_next_s = ZONE_CLEAR;
               end
            end
            ZONE_NEAR: begin
               if (avg_ext_s < STOP_T) begin
                  zone_next_s = ZONE_STOP;
               end else if (avg_ext_s >= NEAR_REL) begin
                  zone_next_s = ZONE_CLEAR;
               end else begin
                  zone_next_s = ZONE_NEAR;
               end
            end
            ZONE_STOP: begin
               if (avg_ext_s >= NEAR_REL) begin
                  zone_next_s = ZONE_CLEAR;
               end else if (avg_ext_s >= STOP_REL) begin
                  zone_next_s = ZONE_NEAR;
               end else begin
                  zone_next_s = ZONE_STOP;
               end
            end
            default: zone_next_s = ZONE_CLEAR;
         endcase
      end else begin
         zone_next_s = zone_r;
      end
   end

   // Zone state register.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         zone_r <= ZONE_CLEAR;
      end else begin
         zone_r <= zone_next_s;
      end
   end

   assign zone = zone_r;

   // Circular sample buffer.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            buf_r[i] <= {DW{1'b0}};
         end
      end else if (buf_acc_s) begin
         buf_r[wr_r] <= buf_in_s;
      end
   end

   // Sum, pointer, fill, timeout and registered outputs.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sum_r        <= {SW{1'b0}};
         wr_r         <= {AVG_LOG2{1'b0}};
         fill_r       <= {(AVG_LOG2 + 1){1'b0}};
         tmo_r        <= {TW{1'b0}};
         avg_distance <= {DW{1'b0}};
         avg_valid    <= 1'b0;
         ready        <= 1'b0;
         sensor_fault <= 1'b0;
         obstacle     <= 1'b1;
      end else begin
         if (buf_acc_s) begin
            sum_r <= new_sum_s;
            wr_r  <= wr_r + WR_ONE;
         end
         fill_r       <= fill_next_s;
         tmo_r        <= tmo_next_s;
         ready        <= ready_next_s;
         sensor_fault <= fault_next_s;
         avg_valid    <= avg_upd_s;
         if (avg_upd_s) begin
            avg_distance <= new_avg_s;
         end
         obstacle <= (~ready_next_s) | (zone_next_s == ZONE_STOP) | fault_next_s;
      end
   end

endmodule

// File: tb/tb_range_monitor.sv
// ---------------------------------------------------------------------------
// tb_range_monitor
//   Directed testbench for range_monitor with hand-computed expectations.
//   Instantiated with TIMEOUT_CYCLES = 1000 so the fault path is reachable.
// ---------------------------------------------------------------------------
module tb_range_monitor;

   logic       CLOCK_50;
   logic       reset;
   logic       sample_valid;
   logic [7:0] sample_distance;
   logic [7:0] avg_distance;
   logic       avg_valid;
   logic       ready;
   logic [1:0] zone;
   logic       sensor_fault;
   logic       obstacle;

   int total;
   int bad;

   range_monitor #(
      .DW             (8),
      .AVG_LOG2       (2),
      .NEAR_CM        (40),
      .STOP_CM        (20),
      .HYST_CM        (5),
      .TIMEOUT_CYCLES (1000)
   ) dut (
      .CLOCK_50        (CLOCK_50),
      .reset           (reset),
      .sample_valid    (sample_valid),
      .sample_distance (sample_distance),
      .avg_distance    (avg_distance),
      .avg_valid       (avg_valid),
      .ready           (ready),
      .zone            (zone),
      .sensor_fault    (sensor_fault),
      .obstacle        (obstacle)
   );

   // 50 MHz clock
   initial begin
      CLOCK_50 = 1'b0;
      forever #10 CLOCK_50 = ~CLOCK_50;
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   // Strobe one sample; returns one step after the capturing edge.
   task automatic send(input logic [7:0] v);
      sample_valid    = 1'b1;
      sample_distance = v;
      @(posedge CLOCK_50);
      #1;
      sample_valid    = 1'b0;
      sample_distance = 8'd0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge CLOCK_50);
      #1;
      reset = 1'b0;
   endtask

   task automatic fill(input logic [7:0] v);
      for (int i = 0; i < 4; i++) begin
         send(v);
         idle(3);
      end
   endtask

   // Send one sample, then check the average pulse and zone.
   task automatic step(input string tag, input logic [7:0] v, input logic [7:0] exp_avg,
                       input logic [1:0] exp_zone);
      send(v);
      check({tag, "_valid"}, avg_valid, 1);
      check({tag, "_avg"}, avg_distance, exp_avg);
      check({tag, "_zone"}, zone, exp_zone);
      idle(3);
   endtask

   initial begin
      total           = 0;
      bad             = 0;
      reset           = 1'b1;
      sample_valid    = 1'b0;
      sample_distance = 8'd0;
      idle(3);

      check("rst_avg", avg_distance, 0);
      check("rst_avg_valid", avg_valid, 0);
      check("rst_ready", ready, 0);
      check("rst_zone", zone, 0);
      check("rst_fault", sensor_fault, 0);
      check("rst_obstacle", obstacle, 1);
      reset = 1'b0;
      idle(2);

`ifdef RANGE_MONITOR_MEDIAN3_EN
      // Median build: six accepts fill the window, avg two cycles after strobe.
      for (int i = 0; i < 5; i++) begin
         send(8'd100);
         idle(3);
      end
      check("m_warm_ready", ready, 0);
      send(8'd100);
      check("m_fill_p1", avg_valid, 0);
      idle(1);
      check("m_fill_p2", avg_valid, 1);
      check("m_fill_avg", avg_distance, 100);
      check("m_fill_ready", ready, 1);
      check("m_fill_obst", obstacle, 0);
      idle(3);
      begin
         logic [7:0] mseq [3];
         mseq[0] = 8'd100;
         mseq[1] = 8'd5;
         mseq[2] = 8'd100;
         for (int i = 0; i < 3; i++) begin
            send(mseq[i]);
            check("m_seq_p1", avg_valid, 0);
            idle(1);
            check("m_seq_p2", avg_valid, 1);
            check("m_seq_avg", avg_distance, 100);
            check("m_seq_zone", zone, 0);
            idle(3);
         end
      end
`else
      // 1: warm-up with four samples of 100.
      for (int i = 0; i < 3; i++) begin
         send(8'd100);
         check("t1_warm_valid", avg_valid, 0);
         check("t1_warm_ready", ready, 0);
         check("t1_warm_obst", obstacle, 1);
         idle(9);
      end
      send(8'd100);
      check("t1_valid", avg_valid, 1);
      check("t1_avg", avg_distance, 100);
      check("t1_ready", ready, 1);
      check("t1_zone", zone, 0);
      check("t1_obst", obstacle, 0);
      idle(1);
      check("t1_pulse_end", avg_valid, 0);
      idle(3);

      // 2: descent into NEAR and hysteretic release to CLEAR.
      step("t2_30a", 8'd30, 8'd82, 2'd0);
      step("t2_30b", 8'd30, 8'd65, 2'd0);
      step("t2_30c", 8'd30, 8'd47, 2'd0);
      step("t2_30d", 8'd30, 8'd30, 2'd1);
      step("t2_42a", 8'd42, 8'd33, 2'd1);
      step("t2_42b", 8'd42, 8'd36, 2'd1);
      step("t2_42c", 8'd42, 8'd39, 2'd1);
      step("t2_42d", 8'd42, 8'd42, 2'd1);
      step("t2_50a", 8'd50, 8'd44, 2'd1);
      step("t2_50b", 8'd50, 8'd46, 2'd0);

      // 3: STOP and release to NEAR at STOP+HYST.
      do_reset();
      check("t3_rst_ready", ready, 0);
      check("t3_rst_obst", obstacle, 1);
      fill(8'd10);
      check("t3_stop_avg", avg_distance, 10);
      check("t3_stop_zone", zone, 2);
      check("t3_stop_obst", obstacle, 1);
      step("t3_a", 8'd30, 8'd15, 2'd2);
      step("t3_b", 8'd30, 8'd20, 2'd2);
      check("t3_b_obst", obstacle, 1);
      step("t3_c", 8'd30, 8'd25, 2'd1);
      check("t3_c_obst", obstacle, 0);
      step("t3_d", 8'd30, 8'd30, 2'd1);

      // 4: zero sample dropped.
      do_reset();
      fill(8'd100);
      send(8'd0);
      check("t4_zero_valid", avg_valid, 0);
      check("t4_zero_avg", avg_distance, 100);
      idle(3);
      step("t4_60", 8'd60, 8'd90, 2'd0);

      // 5: timeout, accept at the limit, zero sample does not reload.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         if (i != 0) idle(3);
         send(8'd100);
      end
      check("t5_fill_ready", ready, 1);
      idle(999);
      check("t5_edge_pre", sensor_fault, 0);
      send(8'd100);
      check("t5_edge_fault", sensor_fault, 0);
      check("t5_edge_valid", avg_valid, 1);
      idle(499);
      send(8'd0);
      idle(499);
      check("t5_pre_fault", sensor_fault, 0);
      idle(1);
      check("t5_fault", sensor_fault, 1);
      check("t5_fault_obst", obstacle, 1);
      check("t5_fault_zone", zone, 0);
      check("t5_fault_ready", ready, 1);
      idle(5);
      check("t5_fault_hold", sensor_fault, 1);
      send(8'd100);
      check("t5_clear_fault", sensor_fault, 0);
      check("t5_clear_obst", obstacle, 0);
      check("t5_clear_avg", avg_distance, 100);
      idle(3);

      // 5b: reset mid-warm-up discards history.
      do_reset();
      send(8'd100);
      idle(3);
      send(8'd100);
      idle(3);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         send(8'd60);
         check("t5b_warm_ready", ready, 0);
         check("t5b_warm_valid", avg_valid, 0);
         idle(3);
      end
      send(8'd60);
      check("t5b_ready", ready, 1);
      check("t5b_valid", avg_valid, 1);
      check("t5b_avg", avg_distance, 60);
      idle(3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
